// File: rtl/timer_controller_param.sv
// mm:ss BCD timer controller: preset entry, count down/up with pause, DONE alarm
// with optional bounded blink, re-edit from STOP and repeat-run from DONE.
module timer_controller_param #(
   parameter int TICK_DIV      = 50000000,
   parameter int BLINK_DIV     = 25000000,
   parameter int ALARM_TOGGLES = 0
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       set_p,
   input  logic       run_p,
   input  logic       mode_up,
   input  logic [3:0] din_lo,
   input  logic [3:0] din_hi,
   output logic [3:0] unit_sec,
   output logic [3:0] tens_sec,
   output logic [3:0] unit_min,
   output logic [3:0] tens_min,
   output logic       timesup,
   output logic       alarm,
   output logic       running,
   output logic [2:0] state
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int BW = $clog2(BLINK_DIV);
   localparam int TW = (ALARM_TOGGLES > 1) ? $clog2(ALARM_TOGGLES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [TW-1:0] TOG_LAST   = TW'((ALARM_TOGGLES > 0) ? ALARM_TOGGLES - 1 : 0);

   typedef enum logic [2:0] {
      IDLE = 3'd0, SETSEC = 3'd1, SETMIN = 3'd2, RUN = 3'd3, STOP = 3'd4, DONE = 3'd5
   } state_t;

   typedef struct packed {
      logic [3:0] mt;
      logic [3:0] mu;
      logic [3:0] st;
      logic [3:0] su;
   } bcd_t;

   function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] mx);
      return (d > mx) ? mx : d;
   endfunction

   function automatic bcd_t bcd_dec(input bcd_t v);
      bcd_t r;
      r = v;
      if (v.su != 4'd0) r.su = v.su - 4'd1;
      else begin
         r.su = 4'd9;
         if (v.st != 4'd0) r.st = v.st - 4'd1;
         else begin
            r.st = 4'd5;
            if (v.mu != 4'd0) r.mu = v.mu - 4'd1;
            else begin
               r.mu = 4'd9;
               r.mt = v.mt - 4'd1;
            end
         end
      end
      return r;
   endfunction

   function automatic bcd_t bcd_inc(input bcd_t v);
      bcd_t r;
      r = v;
      if (v.su != 4'd9) r.su = v.su + 4'd1;
      else begin
         r.su = 4'd0;
         if (v.st != 4'd5) r.st = v.st + 4'd1;
         else begin
            r.st = 4'd0;
            if (v.mu != 4'd9) r.mu = v.mu + 4'd1;
            else begin
               r.mu = 4'd0;
               r.mt = v.mt + 4'd1;
            end
         end
      end
      return r;
   endfunction

   state_t        state_q, state_d;
   bcd_t          cnt, preset, cnt_step, reload;
   logic [PW-1:0] presc;
   logic [BW-1:0] blink;
   logic [TW-1:0] toggles;
   logic          mode_q;
   logic [7:0]    sec_in, min_in;
   logic          tick, at_term, empty, blink_wrap, expire;

   // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
   always_comb begin
      sec_in     = {clamp(din_hi, 4'd5), clamp(din_lo, 4'd9)};
      min_in     = {clamp(din_hi, 4'd9), clamp(din_lo, 4'd9)};
      tick       = (state_q == RUN) && (presc == PRESC_LAST);
      cnt_step   = mode_q ? bcd_inc(cnt) : bcd_dec(cnt);
      at_term    = mode_q ? (cnt_step == preset) : (cnt_step == '0);
      empty      = mode_q ? (preset == '0) : (cnt == '0);
      reload     = mode_q ? '0 : preset;
      blink_wrap = (blink == BLINK_LAST);
      expire     = (ALARM_TOGGLES != 0) && blink_wrap && (toggles == TOG_LAST);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLOCK_50) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (set_p) state_d = SETSEC;
         SETSEC:  if (set_p) state_d = SETMIN;
         SETMIN:  if (set_p) state_d = STOP;
         STOP:    if (set_p) state_d = SETSEC;
                  else if (run_p) state_d = empty ? DONE : RUN;
         RUN:     if (tick && at_term) state_d = DONE;
                  else if (run_p) state_d = STOP;
         DONE:    if (set_p) state_d = SETSEC;
                  else if (run_p) state_d = STOP;
                  else if (expire) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         cnt     <= '0;
         preset  <= '0;
         presc   <= '0;
         blink   <= '0;
         toggles <= '0;
         mode_q  <= 1'b0;
         alarm   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE:   cnt <= '0;
            SETSEC: begin
               {preset.st, preset.su} <= sec_in;
               cnt <= {preset.mt, preset.mu, sec_in};
            end
            SETMIN: begin
               {preset.mt, preset.mu} <= min_in;
               cnt <= (set_p && mode_up) ? '0 : {min_in, preset.st, preset.su};
               if (set_p) begin
                  mode_q <= mode_up;
                  presc  <= '0;
               end
            end
            RUN: begin
               presc <= tick ? '0 : presc + 1'b1;
               if (tick) cnt <= cnt_step;
            end
            DONE: begin
               if (!set_p && run_p) begin
                  cnt   <= reload;
                  presc <= '0;
               end else if (!set_p && expire) cnt <= '0;
            end
            default: ;
         endcase

         // Alarm restarts high on every entry to DONE and is cleared on any exit.
         if (state_d == DONE && state_q != DONE) begin
            alarm   <= 1'b1;
            blink   <= '0;
            toggles <= '0;
         end else if (state_d == DONE) begin
            if (blink_wrap) begin
               blink   <= '0;
               alarm   <= ~alarm;
               toggles <= toggles + 1'b1;
            end else begin
               blink <= blink + 1'b1;
            end
         end else begin
            alarm <= 1'b0;
         end
      end
   end

   always_comb begin
      state    = state_q;
      timesup  = (state_q == DONE);
      running  = (state_q == RUN);
      unit_sec = cnt.su;
      tens_sec = cnt.st;
      unit_min = cnt.mu;
      tens_min = cnt.mt;
   end
endmodule

// File: tb/tb_timer_controller_param.sv
// Bench for timer_controller_param: directed scenarios plus random pulses, checked
// every cycle against a seconds-based behavioural model.
module tb_timer_controller_param;
   localparam int TICK  = 4;
   localparam int BLINK = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1, set_p = 1'b0, run_p = 1'b0, mode_up = 1'b0;
   logic [3:0] din_lo = 4'd0, din_hi = 4'd0;
   logic       sel = 1'b0;   // 0: endless-blink instance, 1: three-toggle instance
   logic       rst_a, rst_b;
   assign rst_a = reset | sel;
   assign rst_b = reset | ~sel;

   logic [3:0] a_us, a_ts, a_um, a_tm, b_us, b_ts, b_um, b_tm;
   logic       a_ti, a_al, a_ru, b_ti, b_al, b_ru;
   logic [2:0] a_st, b_st;

   timer_controller_param #(.TICK_DIV(TICK), .BLINK_DIV(BLINK), .ALARM_TOGGLES(0)) dut_a (
      .CLOCK_50(clk), .reset(rst_a), .set_p(set_p), .run_p(run_p), .mode_up(mode_up),
      .din_lo(din_lo), .din_hi(din_hi), .unit_sec(a_us), .tens_sec(a_ts), .unit_min(a_um),
      .tens_min(a_tm), .timesup(a_ti), .alarm(a_al), .running(a_ru), .state(a_st));

   timer_controller_param #(.TICK_DIV(TICK), .BLINK_DIV(BLINK), .ALARM_TOGGLES(3)) dut_b (
      .CLOCK_50(clk), .reset(rst_b), .set_p(set_p), .run_p(run_p), .mode_up(mode_up),
      .din_lo(din_lo), .din_hi(din_hi), .unit_sec(b_us), .tens_sec(b_ts), .unit_min(b_um),
      .tens_min(b_tm), .timesup(b_ti), .alarm(b_al), .running(b_ru), .state(b_st));

   logic [15:0] o_dig;
   logic [2:0]  o_st;
   logic        o_ti, o_al, o_ru;
   assign o_dig = sel ? {b_tm, b_um, b_ts, b_us} : {a_tm, a_um, a_ts, a_us};
   assign o_st  = sel ? b_st : a_st;
   assign o_ti  = sel ? b_ti : a_ti;
   assign o_al  = sel ? b_al : a_al;
   assign o_ru  = sel ? b_ru : a_ru;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: count and preset held as plain seconds.
   int m_state, m_pmin, m_psec, m_cnt, m_phase, m_dcyc;
   bit m_up;

   function automatic int lim(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic int preset_secs();
      return m_pmin * 60 + m_psec;
   endfunction

   task automatic model_reset();
      m_state = 0; m_pmin = 0; m_psec = 0; m_cnt = 0; m_phase = 0; m_dcyc = 0; m_up = 0;
   endtask

   task automatic enter_done();
      m_state = 5;
      m_dcyc  = 0;
   endtask

   task automatic model_step();
      int at;
      bit tk;
      at = sel ? 3 : 0;
      if (reset) model_reset();
      else begin
         case (m_state)
            0: begin
               m_cnt = 0;
               if (set_p) m_state = 1;
            end
            1: begin
               m_psec = lim(din_hi, 5) * 10 + lim(din_lo, 9);
               m_cnt  = preset_secs();
               if (set_p) m_state = 2;
            end
            2: begin
               m_pmin = lim(din_hi, 9) * 10 + lim(din_lo, 9);
               m_cnt  = preset_secs();
               if (set_p) begin
                  m_up = mode_up; m_phase = 0;
                  if (m_up) m_cnt = 0;
                  m_state = 4;
               end
            end
            3: begin
               tk = 0;
               m_phase++;
               if (m_phase == TICK) begin
                  m_phase = 0; tk = 1;
                  m_cnt += m_up ? 1 : -1;
               end
               if (tk && m_cnt == (m_up ? preset_secs() : 0)) enter_done();
               else if (run_p) m_state = 4;
            end
            4: begin
               if (set_p) m_state = 1;
               else if (run_p) begin
                  if (m_up ? (preset_secs() == 0) : (m_cnt == 0)) enter_done();
                  else m_state = 3;
               end
            end
            5: begin
               if (set_p) m_state = 1;
               else if (run_p) begin
                  m_state = 4; m_phase = 0;
                  m_cnt = m_up ? 0 : preset_secs();
               end else begin
                  m_dcyc++;
                  if (at != 0 && m_dcyc / BLINK == at) begin
                     m_state = 0; m_cnt = 0;
                  end
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      int mm, ss, dig;
      mm  = m_cnt / 60;
      ss  = m_cnt % 60;
      dig = ((mm / 10) << 12) | ((mm % 10) << 8) | ((ss / 10) << 4) | (ss % 10);
      check_eq({tag, " state"}, o_st, m_state);
      check_eq({tag, " digits"}, o_dig, dig);
      check_eq({tag, " timesup"}, o_ti, m_state == 5);
      check_eq({tag, " running"}, o_ru, m_state == 3);
      check_eq({tag, " alarm"}, o_al, (m_state == 5) && ((m_dcyc / BLINK) % 2 == 0));
   endtask

   task automatic cyc(input logic s, input logic r, input string tag);
      set_p = s;
      run_p = r;
      @(posedge clk);
      model_step();
      #1;
      check_outputs(tag);
      set_p = 1'b0;
      run_p = 1'b0;
   endtask

   task automatic load(input int sh, input int sl, input int mh, input int ml, input logic up);
      cyc(1'b1, 1'b0, "to_setsec");
      din_hi = 4'(sh); din_lo = 4'(sl);
      cyc(1'b0, 1'b0, "setsec");
      cyc(1'b1, 1'b0, "to_setmin");
      din_hi = 4'(mh); din_lo = 4'(ml); mode_up = up;
      cyc(1'b1, 1'b0, "to_stop");
   endtask

   task automatic run_until(input int target, input int limit, output int n);
      n = 0;
      while (o_st != 3'(target) && n < limit) begin
         cyc(1'b0, 1'b0, "wait");
         n++;
      end
   endtask

   initial begin
      int n, changes;
      logic prev;
      logic [6:0] pat;

      model_reset();
      reset = 1'b1;
      cyc(1'b0, 1'b0, "rst");
      cyc(1'b0, 1'b0, "rst");
      check_eq("reset_state", o_st, 0);
      check_eq("reset_digits", o_dig, 0);
      check_eq("reset_flags", {o_ti, o_al, o_ru}, 0);
      reset = 1'b0;

      // 00:05 down: DONE 20 cycles after run_p, then the blink pattern
      load(0, 5, 0, 0, 1'b0);
      check_eq("preset_0005", o_dig, 16'h0005);
      cyc(1'b0, 1'b1, "run");
      run_until(5, 40, n);
      check_eq("done_latency", n, 20);
      pat = 7'b1110001;
      for (int i = 0; i < 7; i++) begin
         check_eq("alarm_pattern", o_al, pat[6 - i]);
         if (i < 6) cyc(1'b0, 1'b0, "blink");
      end

      // borrow from 10:00, then pause/resume and stop coincident with a tick
      load(0, 0, 1, 0, 1'b0);
      check_eq("preset_1000", o_dig, 16'h1000);
      cyc(1'b0, 1'b1, "run");
      repeat (3) cyc(1'b0, 1'b0, "pre_tick");
      check_eq("before_tick", o_dig, 16'h1000);
      cyc(1'b0, 1'b0, "tick");
      check_eq("borrow_0959", o_dig, 16'h0959);
      cyc(1'b0, 1'b0, "run");
      cyc(1'b0, 1'b1, "pause");
      check_eq("paused_state", o_st, 4);
      repeat (10) cyc(1'b0, 1'b0, "stopped");
      check_eq("paused_hold", o_dig, 16'h0959);
      cyc(1'b0, 1'b1, "resume");
      cyc(1'b0, 1'b0, "resume1");
      check_eq("resume_no_tick", o_dig, 16'h0959);
      cyc(1'b0, 1'b0, "resume2");
      check_eq("resume_tick", o_dig, 16'h0958);
      repeat (3) cyc(1'b0, 1'b0, "run");
      cyc(1'b0, 1'b1, "stop_on_tick");
      check_eq("stop_tick_state", o_st, 4);
      check_eq("stop_tick_digits", o_dig, 16'h0957);

      // clamping
      cyc(1'b1, 1'b0, "to_setsec");
      din_lo = 4'hC; din_hi = 4'h7;
      cyc(1'b0, 1'b0, "clamp_sec");
      check_eq("clamp_sec", o_dig[7:0], 8'h59);
      cyc(1'b1, 1'b0, "to_setmin");
      cyc(1'b0, 1'b0, "clamp_min");
      check_eq("clamp_min", o_dig[15:8], 8'h79);
      cyc(1'b1, 1'b0, "to_stop");

      // up mode to 01:00, with the 00:59 -> 01:00 carry
      load(0, 0, 0, 1, 1'b1);
      check_eq("up_start", o_dig, 16'h0000);
      cyc(1'b0, 1'b1, "run_up");
      n = 0;
      while (o_st != 3'd5 && n < 300) begin
         cyc(1'b0, 1'b0, "up");
         n++;
         if (n == 236) check_eq("up_0059", o_dig, 16'h0059);
      end
      check_eq("up_latency", n, 240);
      check_eq("up_done_digits", o_dig, 16'h0100);
      cyc(1'b0, 1'b1, "repeat_up");
      check_eq("repeat_up_state", o_st, 4);
      check_eq("repeat_up_digits", o_dig, 16'h0000);

      // zero preset goes straight to DONE
      load(0, 0, 0, 0, 1'b0);
      cyc(1'b0, 1'b1, "run_zero");
      check_eq("zero_done", o_st, 5);

      // reset mid-run at 00:03
      load(0, 5, 0, 0, 1'b0);
      cyc(1'b0, 1'b1, "run");
      repeat (9) cyc(1'b0, 1'b0, "run");
      check_eq("mid_run_0003", o_dig, 16'h0003);
      reset = 1'b1;
      cyc(1'b0, 1'b0, "mid_reset");
      check_eq("mid_reset_state", o_st, 0);
      check_eq("mid_reset_digits", o_dig, 0);
      check_eq("mid_reset_flags", {o_ti, o_al, o_ru}, 0);
      reset = 1'b0;

      // set_p wins over run_p in STOP
      load(0, 3, 0, 0, 1'b0);
      cyc(1'b1, 1'b1, "set_and_run");
      check_eq("set_priority", o_st, 1);

      // three-toggle instance: bounded alarm, then repeat-run from DONE
      sel = 1'b1;
      reset = 1'b1;
      cyc(1'b0, 1'b0, "rst_b");
      cyc(1'b0, 1'b0, "rst_b");
      reset = 1'b0;
      load(0, 2, 0, 0, 1'b0);
      cyc(1'b0, 1'b1, "run");
      run_until(5, 20, n);
      check_eq("b_done_latency", n, 8);
      n = 0; changes = 0; prev = o_al;
      while (o_st == 3'd5 && n < 30) begin
         cyc(1'b0, 1'b0, "b_blink");
         n++;
         if (o_al !== prev) changes++;
         prev = o_al;
      end
      check_eq("b_done_cycles", n, 9);
      check_eq("b_toggles", changes, 3);
      check_eq("b_idle_state", o_st, 0);
      check_eq("b_idle_digits", o_dig, 0);
      check_eq("b_idle_alarm", o_al, 0);
      load(0, 2, 0, 0, 1'b0);
      cyc(1'b0, 1'b1, "run");
      run_until(5, 20, n);
      cyc(1'b0, 1'b0, "done");
      cyc(1'b0, 1'b1, "repeat_down");
      check_eq("repeat_state", o_st, 4);
      check_eq("repeat_digits", o_dig, 16'h0002);
      check_eq("repeat_alarm", o_al, 0);

      // random pulses on both instances against the model
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         reset = 1'b1;
         cyc(1'b0, 1'b0, "rnd_rst");
         cyc(1'b0, 1'b0, "rnd_rst");
         reset = 1'b0;
         for (int k = 0; k < 2500; k++) begin
            din_lo  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            din_hi  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            mode_up = 1'($urandom_range(0, 1));
            reset   = ($urandom_range(0, 999) == 0);
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 11) == 0), "random");
         end
         reset = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/timer_controller_param.md
# timer_controller_param

Parametrised mm:ss timer controller. Generalises the countdown controller: selectable count-down/count-up mode, configurable second-tick and blink dividers, bounded alarm duration, re-edit from STOP, and repeat-run from DONE. It sits between the debounced push-button pulses and switch inputs on one side, and the four 7-segment decoders and LED bank on the other. Counting is done internally in BCD.

## Interface
- TICK_DIV, 50000000: CLOCK_50 cycles per counted second (≥2).
- BLINK_DIV, 25000000: cycles per alarm toggle (≥2).
- ALARM_TOGGLES, 0: number of alarm toggles before the block returns to IDLE; 0 = blink until acknowledged.
- CLOCK_50  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; overrides all other inputs.
- set_p  in  1  single-cycle set pulse (already debounced).
- run_p  in  1  single-cycle start/stop pulse.
- mode_up  in  1  0 = count down from preset; 1 = count up from 00:00 to preset.
- din_lo  in  4  BCD units digit being set.
- din_hi  in  4  BCD tens digit being set.
- unit_sec, tens_sec, unit_min, tens_min  out  4 each  displayed count, BCD.
- timesup  out  1  high while in DONE.
- alarm  out  1  blinking LED drive.
- running  out  1  high while in RUN.
- state  out  3  IDLE=0, SETSEC=1, SETMIN=2, RUN=3, STOP=4, DONE=5.

## Operation
- Registers: preset (4 BCD digits), count (4 BCD digits), prescaler (width clog2(TICK_DIV)), blink counter, toggle counter, latched mode.
- Input clamping on load: din_lo >9 → 9. din_hi >5 → 5 in SETSEC; din_hi >9 → 9 in SETMIN.
- Simultaneous pulses: set_p has priority over run_p.
- IDLE: count = 00:00. set_p → SETSEC. run_p is ignored.
- SETSEC: every cycle, preset seconds ← clamped din, and count mirrors the preset. set_p → SETMIN. run_p is ignored.
- SETMIN: every cycle, preset minutes ← clamped din, and count mirrors the preset. On set_p:
  - latch mode_up;
  - count ← preset (down mode) or 00:00 (up mode);
  - prescaler ← 0;
  - → STOP.
- STOP:
  - run_p → RUN, except in down mode with count = 00:00 or in up mode with preset = 00:00, where the block goes → DONE instead.
  - set_p → SETSEC, which re-edits the preset.
- RUN: the prescaler increments each cycle. When the prescaler equals TICK_DIV-1, it wraps to 0 and a tick occurs:
  - Down mode: BCD decrement with borrow chain su 0→9, st 0→5, mu 0→9, mt−1.
  - Up mode: BCD increment with carry chain su 9→0, st 5→0, mu 9→0, mt+1.
  - If the updated count equals the terminal value (00:00 in down mode, preset in up mode), state → DONE on the same edge.
  - run_p → STOP. The prescaler is held, not cleared, so a partial second is preserved.
  - If a tick and run_p occur in the same cycle, the tick is applied and the state then goes to STOP.
  - set_p is ignored in RUN.
- DONE:
  - On entry, alarm ← 1 and the blink and toggle counters ← 0.
  - alarm inverts every BLINK_DIV cycles.
  - If ALARM_TOGGLES≠0, after the ALARM_TOGGLES-th inversion the block goes → IDLE with alarm ← 0.
  - run_p → STOP with count reloaded as in SETMIN exit (same mode, prescaler ← 0), alarm ← 0. This is the repeat run.
  - set_p → SETSEC, alarm ← 0.
- Count is frozen outside RUN, except for mirroring in SETSEC/SETMIN and reloads.

## Timing
- Reset values: state=IDLE, all digits 0, preset 0, prescaler 0, timesup=0, alarm=0, running=0.
- All outputs are registered. An input pulse at edge N is reflected on the outputs after edge N.
- First tick after STOP→RUN with a cleared prescaler: TICK_DIV cycles after the run_p edge.
- Preset of S seconds in down mode: DONE reached S·TICK_DIV cycles after run_p, excluding stopped time.
- timesup and running are decoded from the registered state and are valid in the same cycle as state.
- A reset asserted mid-RUN or mid-DONE returns the block to reset values on the next edge, with no partial tick.

## Test plan
- TICK_DIV=4, BLINK_DIV=3, ALARM_TOGGLES=0. Set din=0x5/0x0 in SETSEC, then 0x0/0x0 in SETMIN, down mode, run_p → count 00:05→00:00 at 4-cycle spacing. DONE is entered 20 cycles after run_p. alarm pattern is 1,1,1,0,0,0,1…
- Borrow/carry: down from 10:00, one tick → 09:59. Up mode with preset 01:00: ticks 00:59→01:00, which enters DONE.
- Clamping: din_lo=0xC, din_hi=0x7 in SETSEC → preset seconds 59. The same values in SETMIN → preset minutes 79.
- Pause/resume: run_p 2 cycles into a second, stop for 10 cycles, then run_p again → next tick 2 cycles after resume. Also, run_p coincident with a tick → decremented value held, state STOP.
- ALARM_TOGGLES=3: DONE → alarm inverts 3 times, then IDLE with 00:00. Separately, run_p in DONE → STOP with count=preset. Zero preset, down mode, run_p → DONE immediately.
- Reset mid-RUN at count 00:03 → next cycle all digits 0, state 0, timesup/alarm/running 0. set_p and run_p in the same cycle in STOP → SETSEC.
